keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver. The display driver strobes anodes to write digits; this block strobes columns of a 4x4 hex keypad to read keys.
- It debounces key presses and emits one hex code per press.
- It shifts each accepted code into a 32-bit value that drives the display path's inVal[31:0] directly, so the display shows the last 8 keys entered.

Parameters:
- SCAN_DIV, 100000: clocks spent on each column (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- row  input  4  keypad rows, active-low (externally pulled up), asynchronous to clk
- clr  input  1  synchronous clear of inVal, active-high, single-cycle pulse
- col  output 4  keypad column drive, active-low, exactly one bit low at any time
- key_code  output 4  code of the last accepted key
- key_valid  output 1  one-cycle pulse per accepted press
- key_held  output 1  high while an accepted key has not yet been released
- inVal  output 32  shift register of entered codes; newest code in [3:0]

Behaviour:
- Reset (rst=0, asynchronous):
  - col=4'b1110, key_code=0, key_valid=0, key_held=0, inVal=0.
  - Divider=0, column index=0, debounce counter=0, FSM=IDLE.
- Row sampling:
  - row passes through a 2-flop synchronizer.
  - The synchronized row is sampled on the divider's last count (SCAN_DIV-1) for the current column, giving SCAN_DIV-3 clocks of settling.
- Column stepping:
  - On the divider's last count, the column index increments and wraps 3->0.
  - col = ~(4'b0001 << index).
- Scan result:
  - Each sample ORs the pressed rows into a per-scan record.
  - At the end of column 3 (one full scan = 4*SCAN_DIV clocks), the scan result is evaluated:
    - exactly one key down -> KEY with code = {row_idx[1:0], col_idx[1:0]}. Example: row1/col2 -> 4'h6.
    - zero keys down -> NONE.
    - two or more keys down (ghosting) -> NONE.
  - The record clears for the next scan.
- FSM, evaluated once per scan-end:
  - IDLE:
    - KEY -> CAND; store the code; count=1.
    - If DEBOUNCE_SCANS==1, accept the key immediately (see acceptance).
  - CAND:
    - Same code -> count+1.
    - Count reaching DEBOUNCE_SCANS -> accept; go to HELD.
    - Different code -> restart CAND with the new code, count=1.
    - NONE -> IDLE.
  - HELD:
    - NONE -> REL; count=1.
    - Any KEY (same or different) -> stay in HELD. A new key is never accepted without a debounced release first.
  - REL:
    - NONE -> count+1; count reaching DEBOUNCE_SCANS -> IDLE; key_held=0.
    - Any KEY -> HELD.
- Acceptance, registered, on the clock after the deciding scan-end:
  - key_valid=1 for exactly one cycle.
  - key_code = code.
  - key_held=1.
  - inVal <= {inVal[27:0], code}.
- Latency: a clean press that is stable from scan start produces key_valid DEBOUNCE_SCANS scans plus at most 1 scan of alignment plus 3 clocks after the press.
- clr:
  - Sets inVal=0 on the next edge.
  - If clr and acceptance occur in the same cycle, clr wins: inVal=0, while key_valid still pulses and key_code still updates.
- Reset mid-press: returns the FSM to IDLE. A key still held after reset is accepted again once debounced.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, scan = 16 clocks):
- Reset check: hold rst=0, then release. Required: col=1110, and col steps to 1101, 1011, 0111, 1110 every 4 clocks; all other outputs 0.
- Clean press: model row1 low whenever col2 is driven, held for 6 scans. Required: one key_valid pulse, key_code=4'h6, inVal=32'h00000006, key_held=1 until 2 NONE scans after release.
- Bounce rejection:
  - Press key 0x6 for 1 scan, release 1 scan, repeat 3 times. Required: no key_valid.
  - Then hold for 3 scans. Required: exactly one pulse.
- Digit sequence: enter keys 1,2,3,...,9 as clean press/release pairs. Required: 9 pulses, final inVal=32'h23456789.
- Ghosting and rollover:
  - Press 0x6 and 0x9 together. Required: no pulse.
  - Press 0x6, then add 0x9 while 0x6 is held, then release both. Required: exactly one pulse (code 6).
- clr collision: assert clr in the same cycle as an acceptance of 0xA with inVal=32'h12. Required: inVal=0 next cycle, key_valid=1, key_code=4'hA.
- Async reset mid-HELD: drop rst between clock edges. Required: all outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: strobes active-low columns, debounces whole-keypad scans,
// and shifts each accepted code into a 32-bit display value.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    input  logic        clr,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] inVal
);

    // state | meaning
    // IDLE  | no key down, waiting for a single-key scan
    // CAND  | candidate key seen, counting identical scans
    // HELD  | key accepted, waiting for an empty scan
    // REL   | empty scans seen, counting toward release
    typedef enum logic [1:0] {IDLE, CAND, HELD, REL} state_t;

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);
    localparam bit DEB_ONE = (DEBOUNCE_SCANS == 1);

    state_t        state_q;
    logic [3:0]    row_meta_q, row_sync_q;
    logic [DW-1:0] div_q;
    logic [1:0]    idx_q;
    logic [3:0]    col_q;
    logic [15:0]   rec_q;
    logic [3:0]    cand_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_held_q;
    logic [31:0]   inval_q;

    logic          col_last;
    logic          scan_end;
    logic [1:0]    idx_d;
    logic [15:0]   rec_d;
    logic          scan_key;
    logic [3:0]    scan_code;
    logic [CW-1:0] cnt_inc;
    logic          accept;

    assign col_last = (div_q == DIV_LAST);
    assign scan_end = col_last && (idx_q == 2'd3);
    assign idx_d    = idx_q + 2'd1;
    assign cnt_inc  = cnt_q + CW'(1);

    // Record bit index is {row, col}, which is exactly the key code.
    always_comb begin
        rec_d = rec_q;
        if (col_last) begin
            for (int r = 0; r < 4; r++) begin
                if (!row_sync_q[r]) rec_d[{2'(r), idx_q}] = 1'b1;
            end
        end
    end

    always_comb begin
        scan_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (rec_d[i]) scan_code = 4'(i);
        end
    end

    // Ghosted or multi-key scans fail the one-hot test and read as no key.
    assign scan_key = (rec_d != 16'd0) && ((rec_d & (rec_d - 16'd1)) == 16'd0);

    assign accept = scan_end && scan_key &&
                    (((state_q == IDLE) && DEB_ONE) ||
                     ((state_q == CAND) && (scan_code == cand_q) && (cnt_inc == CNT_DONE)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_q       <= '0;
            idx_q       <= 2'd0;
            col_q       <= 4'b1110;
            rec_q       <= 16'd0;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            inval_q     <= 32'd0;
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            key_valid_q <= 1'b0;

            if (col_last) begin
                div_q <= '0;
                idx_q <= idx_d;
                col_q <= ~(4'b0001 << idx_d);
                rec_q <= scan_end ? 16'd0 : rec_d;
            end else begin
                div_q <= div_q + DW'(1);
            end

            if (accept) begin
                key_valid_q <= 1'b1;
                key_code_q  <= scan_code;
                key_held_q  <= 1'b1;
            end

            if (clr)
                inval_q <= 32'd0;
            else if (accept)
                inval_q <= {inval_q[27:0], scan_code};

            if (scan_end) begin
                case (state_q)
                    IDLE: begin
                        if (scan_key) begin
                            cand_q  <= scan_code;
                            cnt_q   <= CW'(1);
                            state_q <= DEB_ONE ? HELD : CAND;
                        end
                    end
                    CAND: begin
                        if (!scan_key) begin
                            state_q <= IDLE;
                        end else if (scan_code == cand_q) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == CNT_DONE) state_q <= HELD;
                        end else begin
                            cand_q <= scan_code;
                            cnt_q  <= CW'(1);
                        end
                    end
                    HELD: begin
                        if (!scan_key) begin
                            if (DEB_ONE) begin
                                state_q    <= IDLE;
                                key_held_q <= 1'b0;
                            end else begin
                                state_q <= REL;
                                cnt_q   <= CW'(1);
                            end
                        end
                    end
                    REL: begin
                        if (scan_key) begin
                            state_q <= HELD;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                state_q    <= IDLE;
                                key_held_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign inVal     = inval_q;

endmodule
